// File: rtl/instr_mem_loader.sv
// Instruction-memory loader.
// Receives a program image as a byte stream and writes 32-bit little-endian words
// into instruction memory from BASE_ADDR upwards. The core is held in reset while a
// session runs, and it is released only after the image checksum has been verified.
// Frame layout: LEN_LO, LEN_HI (word count N), N*4 data bytes, CSUM (XOR of data bytes).
module instr_mem_loader #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0040_0000,
  parameter int          MAX_WORDS  = 1024,
  parameter int          TIMEOUT    = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  // The length field is 16 bits. The word index must be able to hold MAX_WORDS.
  localparam int LEN_W = 16;
  localparam int IDX_W = $clog2(MAX_WORDS + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              len_lo_q, len_lo_d;
  logic [IDX_W-1:0]        len_q, len_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic [IDX_W-1:0]        widx_q, widx_d;
  logic [7:0]              csum_q, csum_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic                    we_q, we_d;
  logic [31:0]             addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic [LEN_W-1:0]        len_full;
  logic                    in_session;

  // Assemble the full length field from the captured low byte and the byte now arriving.
  assign len_full   = {rx_data, len_lo_q};
  assign in_session = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);

  // State and datapath registers. All of them are cleared on asynchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_lo_q   <= '0;
      len_q      <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      widx_q     <= '0;
      csum_q     <= '0;
      tmo_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      widx_q     <= widx_d;
      csum_q     <= csum_d;
      tmo_q      <= tmo_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Next-state logic: frame parsing, word assembly, write generation and idle timeout.
  // NOTE: every next-state signal gets a hold/default value first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    widx_d     = widx_q;
    csum_d     = csum_q;
    tmo_d      = tmo_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      // Idle or a finished session: only start does anything, and any byte arriving
      // in the same cycle is dropped.
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN0;
          csum_d     = '0;
          byte_idx_d = '0;
          widx_d     = '0;
          word_d     = '0;
          len_d      = '0;
          tmo_d      = '0;
        end
      end

      S_LEN0: begin
        if (rx_valid) begin
          len_lo_d = rx_data;
          state_d  = S_LEN1;
        end
      end

      // A zero-length image, or one larger than the memory, is rejected before any write.
      S_LEN1: begin
        if (rx_valid) begin
          if ((len_full == '0) || (len_full > LEN_W'(MAX_WORDS))) begin
            state_d = S_ERR;
          end else begin
            len_d   = len_full[IDX_W-1:0];
            state_d = S_DATA;
          end
        end
      end

      // Bytes fill lanes 0..3. On the fourth byte, the write is registered so that mem_we
      // rises in the following cycle. Input is never stalled, so the next byte may
      // arrive while that write is still on the port.
      S_DATA: begin
        if (rx_valid) begin
          csum_d                          = csum_q ^ rx_data;
          byte_idx_d                      = byte_idx_q + 2'd1;
          word_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
          if (byte_idx_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + 32'({widx_q, 2'b00});
            wdata_d = {rx_data, word_q[DATA_WIDTH-9:0]};
            widx_d  = widx_q + IDX_W'(1);
            if (widx_q == (len_q - IDX_W'(1))) begin
              state_d = S_CSUM;
            end
          end
        end
      end

      S_CSUM: begin
        if (rx_valid) begin
          state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Idle watchdog. Each received byte restarts it. Reaching TIMEOUT idle cycles
    // aborts the session.
    if (in_session) begin
      if (rx_valid) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
        state_d = S_ERR;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  // Moore outputs. A failed image keeps the core in reset.
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = in_session;
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERR);
  assign cpu_hold  = in_session || (state_q == S_ERR);

endmodule
